ieee_divider_seq: RTL and testbench
===================================

// Module: ieee_divider_seq
// PURPOSE
//  Iterative IEEE-754 single-precision divider: result = dividend / divisor.
//  Inverse companion of the FPU multiplier path; same operand format, same truncating rounding.
//  Restoring mantissa division, one quotient bit per clock.
//  Valid/ready handshake on input and output; sits beside the multiplier in the FPU datapath.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MANT_W  23   stored fraction width (hidden bit implicit)
//  BIAS    127  exponent bias
//  Only the defaults are verified.
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   operands valid
//  in_ready   out  1   divider idle, can accept operands
//  dividend   in   32  IEEE-754 single
//  divisor    in   32  IEEE-754 single
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  result     out  32  IEEE-754 single quotient
//  div_zero   out  1   flag: finite nonzero / zero; valid with out_valid
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, div_zero=0, internal regs cleared.
//    Reset mid-operation aborts; no result produced.
//  FSM: IDLE -> DIVIDE -> NORM -> DONE -> IDLE. SPECIAL cases go IDLE -> DONE.
//  IDLE:
//    in_ready=1.
//    On in_valid: latch sign = sa^sb, ea, eb, ma={1,fa}, mb={1,fb}; rem=ma; cnt=0.
//    Classify operands; go to DIVIDE, or DONE with a special result.
//  DIVIDE: 25 cycles, cnt 0..24. Each cycle:
//    if rem>=mb then q bit=1, rem=rem-mb; else q bit=0.
//    Then rem<<=1. q shifts in MSB-first to 25-bit q.
//  NORM (1 cycle): exp = ea - eb + BIAS, computed signed in EXP_W+2 bits.
//    q[24]=1: frac=q[23:1], exp unchanged.
//    q[24]=0: frac=q[22:0], exp=exp-1.
//    exp>=255 -> +/-inf (0x7F800000|sign).
//    exp<=0 -> +/-0 (flush to zero, no denormal output).
//    Rounding: truncate (round toward zero); remainder discarded.
//  DONE:
//    out_valid=1; result/div_zero held stable until out_ready=1.
//    Transfer cycle: out_valid=0 next cycle, return to IDLE.
//    in_ready=0 in every state except IDLE; no operand overlap.
//  Latency: accept edge -> out_valid high 27 cycles later (25 DIVIDE + NORM + DONE entry).
//    Specials: out_valid high 1 cycle after accept.
//  Specials, in priority order; denormal inputs are treated as zero (exp==0):
//    any NaN operand, 0/0, inf/inf -> 0x7FC00000 (canonical qNaN, sign 0)
//    inf/finite -> signed inf
//    finite/inf -> signed 0
//    nonzero/0 -> signed inf, div_zero=1
//    0/nonzero -> signed 0
//  div_zero=0 for all other results.
//  in_valid while busy is ignored: not latched, operand source must hold.
// TESTING
//  1 0x40C00000 / 0x40000000 (6/2) -> 0x40400000 after 27 cycles, div_zero=0
//  2 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated)
//    0xC1200000 / 0x40000000 (-10/2) -> 0xC0A00000
//  3 0x3F800000 / 0x80000000 -> 0xFF800000, div_zero=1, 1-cycle latency
//    0x00000000 / 0x00000000 -> 0x7FC00000, div_zero=0
//  4 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow)
//    0x00800000 / 0x7F000000 -> 0x00000000 (underflow)
//  5 out_ready held 0 for 10 cycles after out_valid:
//    result stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle
//  6 assert rst at DIVIDE cycle 12:
//    outputs return to reset values immediately; next op (6/2) gives 0x40400000

Source files
------------

// File: rtl/ieee_divider_seq_if.sv
// Operand/result handshake bundle for the sequential IEEE-754 divider.
// master drives operands and result acceptance; slave is the divider.
interface ieee_divider_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, result, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, result, div_zero
  );
endinterface

// File: rtl/ieee_divider_seq.sv
// Iterative IEEE-754 single-precision divider, result = dividend / divisor.
// Restoring mantissa division producing one quotient bit per clock,
// truncating rounding, flush-to-zero on underflow, denormal inputs read as zero.
module ieee_divider_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127
) (
  input  logic              clk,
  input  logic              rst,
  ieee_divider_seq_if.slave bus
);
  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int QW = MANT_W + 2;      // quotient bits: integer bit + guard for normalisation
  localparam int RW = MANT_W + 3;      // remainder needs room for the left shift
  localparam int CW = $clog2(QW);
  localparam int EW = EXP_W + 2;       // signed exponent with overflow/underflow headroom

  localparam logic [EXP_W-1:0]        EXP_MAX  = '1;
  localparam logic [CW-1:0]           CNT_LAST = CW'(QW - 1);
  localparam logic signed [EW-1:0]    E_SAT    = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0]    E_ZERO   = '0;
  localparam logic [W-1:0]            QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_NORM,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic                sign;
  logic [EXP_W-1:0]    ea, eb;
  logic [MANT_W:0]     mb;
  logic [RW-1:0]       rem;
  logic [QW-1:0]       q;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        result_r;
  logic                div_zero_r;

  logic                in_ready, out_valid;

  // Operand field split
  logic                a_sign, b_sign;
  logic [EXP_W-1:0]    a_exp, b_exp;
  logic [MANT_W-1:0]   a_frac, b_frac;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                res_sign;

  assign a_sign   = bus.dividend[W-1];
  assign a_exp    = bus.dividend[W-2:MANT_W];
  assign a_frac   = bus.dividend[MANT_W-1:0];
  assign b_sign   = bus.divisor[W-1];
  assign b_exp    = bus.divisor[W-2:MANT_W];
  assign b_frac   = bus.divisor[MANT_W-1:0];
  assign res_sign = a_sign ^ b_sign;

  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_MAX) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_MAX) && (b_frac == '0);
  assign a_nan  = (a_exp == EXP_MAX) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_MAX) && (b_frac != '0);

  // Normalise the raw quotient, truncate the fraction and saturate the exponent.
  function automatic logic [W-1:0] pack_quotient(
    input logic             sg,
    input logic [EXP_W-1:0] xa,
    input logic [EXP_W-1:0] xb,
    input logic [QW-1:0]    qt
  );
    logic signed [EW-1:0] e;
    logic [MANT_W-1:0]    frac;
    e = $signed(EW'(xa)) - $signed(EW'(xb)) + $signed(EW'(BIAS));
    if (qt[QW-1]) begin
      frac = qt[QW-2:1];
    end else begin
      frac = qt[QW-3:0];
      e    = e - EW'(1);
    end
    if (e >= E_SAT)
      pack_quotient = {sg, EXP_MAX, {MANT_W{1'b0}}};
    else if (e <= E_ZERO)
      pack_quotient = {sg, {(W-1){1'b0}}};
    else
      pack_quotient = {sg, e[EXP_W-1:0], frac};
  endfunction

  // Special-operand classification, highest priority first
  logic          is_special;
  logic [W-1:0]  spec_result;
  logic          spec_dz;

  // Decide whether the presented operands bypass the mantissa divider
  always_comb begin
    is_special  = 1'b1;
    spec_result = '0;
    spec_dz     = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result = QNAN;
    end else if (a_inf) begin
      spec_result = {res_sign, EXP_MAX, {MANT_W{1'b0}}};
    end else if (b_inf) begin
      spec_result = {res_sign, {(W-1){1'b0}}};
    end else if (b_zero) begin
      spec_result = {res_sign, EXP_MAX, {MANT_W{1'b0}}};
      spec_dz     = 1'b1;
    end else if (a_zero) begin
      spec_result = {res_sign, {(W-1){1'b0}}};
    end else begin
      is_special  = 1'b0;
    end
  end

  // One restoring-division step on the current remainder
  logic          rem_ge;
  logic [RW-1:0] rem_sub;

  assign rem_ge  = (rem >= RW'(mb));
  assign rem_sub = rem_ge ? (rem - RW'(mb)) : rem;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) next_state = is_special ? S_DONE : S_DIVIDE;
      end
      S_DIVIDE: begin
        if (cnt == CNT_LAST) next_state = S_NORM;
      end
      S_NORM: begin
        next_state = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand latch, quotient iteration and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign       <= 1'b0;
      ea         <= '0;
      eb         <= '0;
      mb         <= '0;
      rem        <= '0;
      q          <= '0;
      cnt        <= '0;
      result_r   <= '0;
      div_zero_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sign <= res_sign;
            ea   <= a_exp;
            eb   <= b_exp;
            mb   <= {1'b1, b_frac};
            rem  <= RW'({1'b1, a_frac});
            q    <= '0;
            cnt  <= '0;
            if (is_special) begin
              result_r   <= spec_result;
              div_zero_r <= spec_dz;
            end
          end
        end
        S_DIVIDE: begin
          rem <= rem_sub << 1;
          q   <= {q[QW-2:0], rem_ge};
          cnt <= cnt + 1'b1;
        end
        S_NORM: begin
          result_r   <= pack_quotient(sign, ea, eb, q);
          div_zero_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_r;
  assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_ieee_divider_seq.sv
// Testbench for ieee_divider_seq: directed vectors, special operands,
// randomized operands against a truncating-division reference, back-pressure
// and reset abort scenarios.
module tb_ieee_divider_seq;
  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  ieee_divider_seq_if bus ();

  ieee_divider_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  // Reference: {div_zero, result} from IEEE semantics with exact truncated quotient
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, sig;
    bit     az, bz, ai, bi, an, bn;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 32'h7FC00000};
    if (ai) return {1'b0, s, 8'hFF, 23'h0};
    if (bi) return {1'b0, s, 31'h0};
    if (bz) return {1'b1, s, 8'hFF, 23'h0};
    if (az) return {1'b0, s, 31'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e  = ea - eb + 127;
    if (ma >= mb) begin
      sig = (ma << 23) / mb;
    end else begin
      sig = (ma << 24) / mb;
      e   = e - 1;
    end
    if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
    if (e <= 0)   return {1'b0, s, 31'h0};
    return {1'b0, s, 8'(e), sig[22:0]};
  endfunction

  function automatic bit is_special_op(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  // Drive one operation, report what came back and edges from accept to out_valid
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic dz, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    dz  = bus.div_zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 00000000", bus.result); end
    n_cmp++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero got %b want 0", bus.div_zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam int ND = 7;
  localparam logic [31:0] D_A   [ND] = '{32'h40C00000, 32'h3F800000, 32'hC1200000, 32'h3F800000,
                                         32'h00000000, 32'h7F000000, 32'h00800000};
  localparam logic [31:0] D_B   [ND] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h80000000,
                                         32'h00000000, 32'h00800000, 32'h7F000000};
  localparam logic [31:0] D_R   [ND] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0A00000, 32'hFF800000,
                                         32'h7FC00000, 32'h7F800000, 32'h00000000};
  localparam logic        D_Z   [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam int          D_L   [ND] = '{27, 27, 27, 1, 1, 27, 27};

  task automatic test_directed();
    logic [31:0] res;
    logic        dz;
    int          lat;
    for (int i = 0; i < ND; i++) begin
      run_op(D_A[i], D_B[i], res, dz, lat);
      n_cmp++; if (res !== D_R[i]) begin n_fail++; $display("FAIL directed_result[%0d] %h/%h got %h want %h", i, D_A[i], D_B[i], res, D_R[i]); end
      n_cmp++; if (dz !== D_Z[i]) begin n_fail++; $display("FAIL directed_div_zero[%0d] got %b want %b", i, dz, D_Z[i]); end
      n_cmp++; if (lat !== D_L[i]) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, D_L[i]); end
    end
  endtask

  localparam int NS = 11;
  localparam logic [31:0] S_A [NS] = '{32'h7F800001, 32'h3F800000, 32'h7F800000, 32'hFF800000,
                                       32'h40000000, 32'h7F800000, 32'hC0400000, 32'h00000000,
                                       32'h80000000, 32'h00000001, 32'h3F800000};
  localparam logic [31:0] S_B [NS] = '{32'h3F800000, 32'hFFC00000, 32'hFF800000, 32'h40000000,
                                       32'hFF800000, 32'h00000000, 32'h00000000, 32'h40A00000,
                                       32'h40A00000, 32'h3F800000, 32'h807FFFFF};

  task automatic test_specials();
    logic [31:0] res;
    logic        dz;
    int          lat;
    logic [32:0] exp_v;
    for (int i = 0; i < NS; i++) begin
      exp_v = model(S_A[i], S_B[i]);
      run_op(S_A[i], S_B[i], res, dz, lat);
      n_cmp++; if (res !== exp_v[31:0]) begin n_fail++; $display("FAIL special_result[%0d] %h/%h got %h want %h", i, S_A[i], S_B[i], res, exp_v[31:0]); end
      n_cmp++; if (dz !== exp_v[32]) begin n_fail++; $display("FAIL special_div_zero[%0d] got %b want %b", i, dz, exp_v[32]); end
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL special_latency[%0d] got %0d want 1", i, lat); end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [7:0] e;
    if ($urandom_range(0, 7) == 0) e = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
    else                           e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic test_random();
    logic [31:0] a, b, res;
    logic        dz;
    int          lat, want_lat;
    logic [32:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      a        = rand_operand();
      b        = rand_operand();
      exp_v    = model(a, b);
      want_lat = is_special_op(a, b) ? 1 : 27;
      run_op(a, b, res, dz, lat);
      n_cmp++; if (res !== exp_v[31:0]) begin n_fail++; $display("FAIL random_result[%0d] %h/%h got %h want %h", i, a, b, res, exp_v[31:0]); end
      n_cmp++; if (dz !== exp_v[32]) begin n_fail++; $display("FAIL random_div_zero[%0d] got %b want %b", i, dz, exp_v[32]); end
      n_cmp++; if (lat !== want_lat) begin n_fail++; $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, want_lat); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    bus.dividend  = 32'h40C00000;
    bus.divisor   = 32'h40000000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== 27) begin n_fail++; $display("FAIL stall_latency got %0d want 27", lat); end
    // Offer a divide-by-zero operand while the result is being held
    bus.dividend = 32'h3F800000;
    bus.divisor  = 32'h00000000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.result !== 32'h40400000) begin n_fail++; $display("FAIL stall_result[%0d] got %h want 40400000", i, bus.result); end
      n_cmp++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL stall_div_zero[%0d] got %b want 0", i, bus.div_zero); end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[%0d] got %b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, bus.in_ready); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_operand_ignored out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        dz;
    int          lat;
    @(negedge clk);
    bus.dividend = 32'h40C00000;
    bus.divisor  = 32'h40000000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL abort_result got %h want 00000000", bus.result); end
    n_cmp++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL abort_div_zero got %b want 0", bus.div_zero); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_result out_valid got %b want 0", bus.out_valid); end
    run_op(32'h40C00000, 32'h40000000, res, dz, lat);
    n_cmp++; if (res !== 32'h40400000) begin n_fail++; $display("FAIL after_abort_result got %h want 40400000", res); end
    n_cmp++; if (lat !== 27) begin n_fail++; $display("FAIL after_abort_latency got %0d want 27", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, res;
    logic        dz;
    int          lat;
    logic [32:0] exp_v;
    for (int i = 0; i < 6; i++) begin
      a     = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      b     = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      exp_v = model(a, b);
      run_op(a, b, res, dz, lat);
      n_cmp++; if (res !== exp_v[31:0]) begin n_fail++; $display("FAIL b2b_result[%0d] %h/%h got %h want %h", i, a, b, res, exp_v[31:0]); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_out_valid[%0d] got %b want 0", i, bus.out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_specials();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
